// File: rtl/afpm_mul_scheduler.sv
// afpm_mul_scheduler: round-robin sharing of one approximate-log FP16
// multiplier among NREQ requesters with zero bypass and a WAIT timeout.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_a/req_b      per-requester operand requests (16b slices)
//   req_ready                  one-hot accept (combinational, IDLE only)
//   rsp_valid/rsp_ready        one-hot registered result handshake
//   rsp_data/rsp_err           shared result, timeout flag
//   mul_start/mul_a/mul_b      issue pulse and held operands
//   mul_done/mul_result        multiplier completion
//   busy, op_count             status: not-idle, completed responses

module afpm_mul_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic                 mul_done,
    input  logic [15:0]          mul_result,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_grant;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [15:0]       r_rsp_data;
    logic              r_rsp_err;
    logic [15:0]       r_mul_a;
    logic [15:0]       r_mul_b;
    logic [15:0]       r_op_count;

    logic              w_found;
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_cand;
    logic [15:0]       w_op_a;
    logic [15:0]       w_op_b;
    logic              w_accept;
    logic              w_zero;
    logic              w_rsp_hs;
    logic              w_mul_start;
    logic [NREQ-1:0]   w_ready;

    // Rotating-priority scan: start just after the previous grant so a
    // requester that was just served goes to the back of the line.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_op_a   = req_a[int'(w_win)*16 +: 16];
    assign w_op_b   = req_b[int'(w_win)*16 +: 16];
    assign w_accept = (r_state == S_IDLE) && w_found;
    // Signed zero in either operand: product is a zero with XOR sign.
    assign w_zero   = (w_op_a[14:0] == 15'd0) || (w_op_b[14:0] == 15'd0);
    assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_grant];

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mul_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mul_start = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done || (r_timer == '0)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= IW'(NREQ - 1);
            r_grant     <= '0;
            r_timer     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_op_count  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mul_a <= w_op_a;
                        r_mul_b <= w_op_b;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        if (w_zero) begin
                            r_rsp_data  <= {w_op_a[15] ^ w_op_b[15], 15'd0};
                            r_rsp_err   <= 1'b0;
                            r_rsp_valid <= NREQ'(1) << w_win;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= TW'(TIMEOUT - 1);
                end
                S_WAIT: begin
                    // Done takes priority over an expiring timer.
                    if (mul_done) begin
                        r_rsp_data  <= mul_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= NREQ'(1) << r_grant;
                    end else if (r_timer == '0) begin
                        r_rsp_data  <= QNAN;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= NREQ'(1) << r_grant;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_op_count  <= r_op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign mul_start = w_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_op_count;

endmodule

// File: doc/afpm_mul_scheduler.md
# afpm_mul_scheduler

Round-robin scheduler that shares one approximate-logarithmic FP16 multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues each accepted operation to the multiplier with a start pulse. It waits for the multiplier's done pulse or a timeout, then returns the 16-bit result to the originating requester. It sits between the pin-level byte collector/serializer front ends and the multiplier datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 32: maximum cycles spent in WAIT before aborting (≥2).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; all state and outputs are cleared while low.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  16*NREQ  FP16 operand A; slice i = [16i+15:16i].
- req_b  in  16*NREQ  FP16 operand B, same slicing.
- req_ready  out  NREQ  one-hot accept, combinational; asserted only in IDLE, for the arbitration winner.
- rsp_valid  out  NREQ  one-hot result valid, registered.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_data  out  16  result, shared across all requesters.
- rsp_err  out  1  result produced by timeout; qualified by rsp_valid.
- mul_start  out  1  one-cycle issue pulse to the multiplier.
- mul_a, mul_b  out  16 each  registered operands, held stable from ISSUE until the next acceptance.
- mul_done  in  1  multiplier completion pulse.
- mul_result  in  16  multiplier result; valid when mul_done is high.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  number of completed responses; wraps from 16'hFFFF to 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitration scans requesters starting at (last_grant+1) mod NREQ; the first with req_valid set wins.
  - req_ready is driven for the winner only.
  - On req_valid&req_ready: capture the operands into mul_a/mul_b, record the grant, set last_grant to the grant.
  - Zero bypass: if either operand[14:0]==0, skip the multiplier. Set rsp_data={a[15]^b[15],15'b0}, rsp_err=0, go to RESP. No mul_start is issued.
  - Otherwise go to ISSUE.
- **ISSUE**: drive mul_start=1 for exactly one cycle, load the timer with TIMEOUT-1, go to WAIT.
- **WAIT**
  - If mul_done: rsp_data<=mul_result, rsp_err<=0, go to RESP.
  - Else if timer==0: rsp_data<=16'h7E00 (qNaN), rsp_err<=1, go to RESP.
  - Else decrement the timer.
  - If mul_done and timer==0 occur in the same cycle, mul_done wins.
- **RESP**
  - rsp_valid[grant] stays high; rsp_data and rsp_err are held.
  - On rsp_ready[grant]: clear rsp_valid, op_count+1, go to IDLE.
  - rsp_ready on non-granted lines is ignored.
- mul_done outside WAIT is ignored and does not alter state.
- Requesters that are not granted keep their req_valid high. They are not dropped.
- Reset values: state=IDLE, last_grant=NREQ-1 (requester 0 has priority first), rsp_valid=0, rsp_data=0, rsp_err=0, mul_start=0, mul_a=mul_b=0, op_count=0, busy=0, timer=0.
- Reset asserted mid-operation aborts immediately. No response is produced; the multiplier's later mul_done is ignored because the FSM is in IDLE.

## Timing
- Cycle 0: acceptance handshake in IDLE.
- Cycle 1: ISSUE, mul_start=1.
- WAIT begins at cycle 2.
- mul_done seen in WAIT at cycle k gives rsp_valid high from cycle k+1.
- Timeout: with no done, rsp_valid rises at cycle 2+TIMEOUT (TIMEOUT WAIT cycles).
- Bypass: rsp_valid high at cycle 1.
- Back-to-back throughput: a response handshake at cycle r allows the next acceptance at cycle r+1.
- Minimum non-bypass period is 4 cycles plus the multiplier latency.
- rsp_valid, rsp_data and rsp_err are stable while rsp_ready is low.

## Test plan
- **Single operation.** Requester 2 sends A=16'h3E00, B=16'h4000. The bench model returns 16'h4200 with mul_done at cycle 9. Required: mul_start only at cycle 1, mul_a=16'h3E00; rsp_valid[2] at cycle 10 with rsp_data=16'h4200, rsp_err=0; op_count=1.
- **Round-robin.** All 4 req_valid held high, rsp_ready tied high, model latency 3. Required: grant order 0,1,2,3,0,1; no requester is granted twice in a row while others are waiting.
- **Zero bypass.** Requester 1 sends A=16'h8000, B=16'h3C00. Required: no mul_start; rsp_valid[1] at cycle 1 with rsp_data=16'h8000.
- **Timeout.** mul_done never asserted, TIMEOUT=32. Required: rsp_valid at cycle 34 with rsp_data=16'h7E00, rsp_err=1. A later stray mul_done is ignored.
- **Backpressure and coincidence.** Hold rsp_ready low for 5 cycles in RESP: outputs stay held, busy=1, no new req_ready. Separately, assert mul_done on the timer==0 cycle: rsp_err=0 and mul_result is forwarded.
- **Reset mid-WAIT.** Pulse rst_n low asynchronously between clock edges. Required: all outputs return to their reset values immediately, no response is issued, and requester 0 wins the first arbitration after reset.
